lr35902_dbg_trig: RTL
=====================

LR35902_DBG_TRIG -- requirements
Module: lr35902_dbg_trig

Interface
REQ-001 SHALL have parameter NUM_BP, default 4, number of trigger channels (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 8, pass-counter width (legal 1..16).
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports pc  in  16  current PC; adr  in  16  bus address; rd, wr, fetch  in  1  bus read, bus write, opcode-fetch strobes.
REQ-006 SHALL have port stepping  in  1  suppresses exec triggers while high.
REQ-007 SHALL have ports cmd_data  in  8  command byte; cmd_valid  in  1  byte valid; cmd_seq  in  1  command toggle; cmd_ack  out  1  command acknowledge toggle.
REQ-008 SHALL have ports rsp_data  out  8  response byte; rsp_seq  out  1  response toggle; rsp_ack  in  1  response acknowledge toggle.
REQ-009 SHALL have ports halt_req  out  1  sticky halt request; hit_id  out  4  index of the triggering channel.

Function
REQ-010 Command pending SHALL mean cmd_seq != cmd_ack; a pending command with cmd_valid=0 SHALL be dropped by setting cmd_ack<=cmd_seq, with no response.
REQ-011 Decode (c = low nibble): 0x0_ NOP; 0x1n stage<={n,stage[15:4]}; 0x2c addr[c]<=stage; 0x3c mask[c]<=stage; 0x4c reload and cnt[c]<=stage[CNT_W-1:0]; 0x5c mode[c]<=stage[2:0] (bit0 exec, bit1 read, bit2 write); 0x60 clear sticky; 0x7c read cnt[c][7:0].
REQ-012 A command with c >= NUM_BP, or an undefined opcode, SHALL be dropped as in REQ-010.
REQ-013 FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE SHALL execute a valid command in one cycle, load rsp_data, toggle rsp_seq and enter SEND.
REQ-015 rsp_data SHALL be cnt[c][7:0] for 0x7c (zero-extended when CNT_W<8); for all other commands it SHALL be {halt_req,3'b000,hit_id}, sampled after the command takes effect.
REQ-016 SEND SHALL wait for rsp_ack==rsp_seq, then set cmd_ack<=cmd_seq and return to IDLE; no new command SHALL be accepted in SEND.
REQ-017 Channel i SHALL match on any of: (mode[0] & fetch & !stepping & ((pc^addr)&~mask)==0), (mode[1] & rd & ((adr^addr)&~mask)==0), (mode[2] & wr & same address test).
REQ-018 On a match with cnt[i]!=0, cnt[i] SHALL decrement by 1 and the match SHALL NOT trigger.
REQ-019 On a match with cnt[i]==0, the channel SHALL trigger, and cnt[i] SHALL stay 0, so every further match triggers.
REQ-020 Triggers SHALL be registered: halt_req SHALL rise exactly 1 cycle after the matching strobe cycle.
REQ-021 When several channels trigger in the same cycle, hit_id SHALL take the lowest index.
REQ-022 halt_req SHALL stay high until command 0x60 or reset; hit_id SHALL hold while halt_req is high, and later triggers SHALL NOT overwrite it.
REQ-023 A 0x60 clear and a trigger in the same cycle SHALL leave halt_req=1, with hit_id set to the new channel.
REQ-024 A 0x4c/0x2c/0x3c/0x5c write and a match on the same channel in the same cycle: the write SHALL win, with no decrement and no trigger from that channel.
REQ-025 Mask bits set to 1 SHALL be don't-care bits; mask 0xFFFF SHALL match every address.

Reset
REQ-026 On reset: addr=0xFFFF, mask=0x0000, mode=0, cnt=0, stage=0, halt_req=0, hit_id=0, rsp_data=0, state IDLE, cmd_ack<=cmd_seq, rsp_seq<=rsp_ack.
REQ-027 Reset mid-SEND SHALL abandon the response, with no further rsp_seq toggle.

Structure
REQ-028 Opcodes, mode bit positions and FSM state encodings SHALL live in shared package lr35902_dbg_pkg.
REQ-029 Per-channel compare/counter logic SHALL be sub-module lr35902_dbg_trig_chan, instantiated NUM_BP times via generate.

Verification
REQ-030 Send 0x1F,0x1F,0x1F,0x1F,0x20,0x51 then fetch with pc=0xFFFF -> halt_req=1 one cycle later, hit_id=0, each command answered with one response.
REQ-031 Set ch1 addr 0xC000, mask 0x00FF, mode 4; write to 0xC0A5 -> hit_id=1; write to 0xC100 -> no trigger.
REQ-032 Set ch2 cnt=3, exec at 0x0150; three fetches -> no halt, 0x72 returns 0x00; fourth fetch -> halt_req=1, hit_id=2.
REQ-033 Ch0 and ch3 match in the same cycle -> hit_id=0; then 0x60 -> response 0x00, halt_req=0.
REQ-034 Exec match with stepping=1 -> no trigger; command with cmd_valid=0 -> cmd_ack toggles, rsp_seq unchanged.
REQ-035 Assert reset while in SEND -> cmd_ack==cmd_seq, rsp_seq==rsp_ack, all channels disabled.

Source files
------------

// File: rtl/lr35902_dbg_pkg.sv
// Shared opcodes, mode-bit positions and FSM encoding for the LR35902 debug trigger block.
package lr35902_dbg_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_STAGE = 4'h1;
   localparam logic [3:0] OP_ADDR  = 4'h2;
   localparam logic [3:0] OP_MASK  = 4'h3;
   localparam logic [3:0] OP_CNT   = 4'h4;
   localparam logic [3:0] OP_MODE  = 4'h5;
   localparam logic [3:0] OP_CLR   = 4'h6;
   localparam logic [3:0] OP_RDCNT = 4'h7;

   localparam int MODE_EXEC = 0;
   localparam int MODE_RD   = 1;
   localparam int MODE_WR   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

endpackage

// File: rtl/lr35902_dbg_trig_chan.sv
// One breakpoint channel: masked PC/bus address compare, pass counter and trigger pulse.
module lr35902_dbg_trig_chan
   import lr35902_dbg_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      pc_i,
   input  logic [15:0]      adr_i,
   input  logic             rd_i,
   input  logic             wr_i,
   input  logic             fetch_i,
   input  logic             stepping_i,
   input  logic [15:0]      stage_i,
   input  logic             wr_addr_i,
   input  logic             wr_mask_i,
   input  logic             wr_cnt_i,
   input  logic             wr_mode_i,
   output logic             trig_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [15:0]      addr_q, mask_q;
   logic [2:0]       mode_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pc_hit, adr_hit, match, cfg_wr;

   assign pc_hit  = ((pc_i  ^ addr_q) & ~mask_q) == 16'h0000;
   assign adr_hit = ((adr_i ^ addr_q) & ~mask_q) == 16'h0000;
   assign match   = (mode_q[MODE_EXEC] & fetch_i & ~stepping_i & pc_hit) |
                    (mode_q[MODE_RD]   & rd_i    & adr_hit) |
                    (mode_q[MODE_WR]   & wr_i    & adr_hit);

   // A config write to this channel in the same cycle masks any match it sees.
   assign cfg_wr = wr_addr_i | wr_mask_i | wr_cnt_i | wr_mode_i;
   assign trig_o = match & ~cfg_wr & (cnt_q == '0);
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_cnt_i)
         cnt_d = stage_i[CNT_W-1:0];
      else if (match && !cfg_wr && cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= 16'hFFFF;
         mask_q <= 16'h0000;
         mode_q <= 3'b000;
         cnt_q  <= '0;
      end else begin
         if (wr_addr_i) addr_q <= stage_i;
         if (wr_mask_i) mask_q <= stage_i;
         if (wr_mode_i) mode_q <= stage_i[2:0];
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lr35902_dbg_trig.sv
// LR35902 debug trigger: toggle-handshake command port, NUM_BP breakpoint channels, sticky halt.
module lr35902_dbg_trig
   import lr35902_dbg_pkg::*;
#(
   parameter int NUM_BP = 4,
   parameter int CNT_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic [15:0] adr,
   input  logic        rd,
   input  logic        wr,
   input  logic        fetch,
   input  logic        stepping,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   input  logic        cmd_seq,
   output logic        cmd_ack,
   output logic [7:0]  rsp_data,
   output logic        rsp_seq,
   input  logic        rsp_ack,
   output logic        halt_req,
   output logic [3:0]  hit_id
);

   localparam logic [4:0] NBP = 5'(NUM_BP);

   state_e      state_q, state_d;
   logic        cmd_ack_q, cmd_ack_d;
   logic        rsp_seq_q, rsp_seq_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic [15:0] stage_q, stage_d;
   logic        halt_q, halt_d;
   logic [3:0]  hit_q, hit_d;

   logic [3:0]  op, c;
   logic        pending, chan_ok, legal, exec, clr, any_trig;
   logic [3:0]  first;
   logic [CNT_W-1:0] cnt_sel;
   logic [7:0]  cnt_byte;

   logic [NUM_BP-1:0]            wr_addr, wr_mask, wr_cnt, wr_mode, trig;
   logic [NUM_BP-1:0][CNT_W-1:0] cnt;

   assign op      = cmd_data[7:4];
   assign c       = cmd_data[3:0];
   assign pending = cmd_seq ^ cmd_ack_q;
   assign chan_ok = {1'b0, c} < NBP;

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_NOP, OP_STAGE:                             legal = 1'b1;
         OP_ADDR, OP_MASK, OP_CNT, OP_MODE, OP_RDCNT:  legal = chan_ok;
         OP_CLR:                                       legal = (c == 4'h0);
         default:                                      legal = 1'b0;
      endcase
   end

   assign exec = (state_q == ST_IDLE) & pending & cmd_valid & legal;
   assign clr  = exec & (op == OP_CLR);

   for (genvar i = 0; i < NUM_BP; i++) begin : g_chan
      assign wr_addr[i] = exec & (op == OP_ADDR) & (c == 4'(i));
      assign wr_mask[i] = exec & (op == OP_MASK) & (c == 4'(i));
      assign wr_cnt[i]  = exec & (op == OP_CNT)  & (c == 4'(i));
      assign wr_mode[i] = exec & (op == OP_MODE) & (c == 4'(i));

      lr35902_dbg_trig_chan #(.CNT_W(CNT_W)) u_chan (
         .clk        (clk),
         .reset      (reset),
         .pc_i       (pc),
         .adr_i      (adr),
         .rd_i       (rd),
         .wr_i       (wr),
         .fetch_i    (fetch),
         .stepping_i (stepping),
         .stage_i    (stage_q),
         .wr_addr_i  (wr_addr[i]),
         .wr_mask_i  (wr_mask[i]),
         .wr_cnt_i   (wr_cnt[i]),
         .wr_mode_i  (wr_mode[i]),
         .trig_o     (trig[i]),
         .cnt_o      (cnt[i])
      );
   end

   // Downward scan so the lowest triggering index is the one left standing.
   always_comb begin
      any_trig = |trig;
      first    = 4'h0;
      for (int i = NUM_BP - 1; i >= 0; i--)
         if (trig[i]) first = 4'(i);
      cnt_sel = '0;
      for (int i = 0; i < NUM_BP; i++)
         if (c == 4'(i)) cnt_sel = cnt[i];
   end

   if (CNT_W >= 8) begin : g_cnt_wide
      assign cnt_byte = cnt_sel[7:0];
   end else begin : g_cnt_narrow
      assign cnt_byte = {{(8 - CNT_W){1'b0}}, cnt_sel};
   end

   // Clear applies first so a same-cycle trigger re-arms halt with the new channel.
   always_comb begin
      halt_d = halt_q;
      hit_d  = hit_q;
      if (clr) halt_d = 1'b0;
      if (any_trig && !halt_d) begin
         halt_d = 1'b1;
         hit_d  = first;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_ack_d  = cmd_ack_q;
      rsp_seq_d  = rsp_seq_q;
      rsp_data_d = rsp_data_q;
      stage_d    = stage_q;
      case (state_q)
         ST_IDLE: begin
            if (exec) begin
               if (op == OP_STAGE) stage_d = {c, stage_q[15:4]};
               rsp_data_d = (op == OP_RDCNT) ? cnt_byte : {halt_d, 3'b000, hit_d};
               rsp_seq_d  = ~rsp_seq_q;
               state_d    = ST_SEND;
            end else if (pending) begin
               cmd_ack_d = cmd_seq;
            end
         end
         ST_SEND: begin
            if (rsp_ack == rsp_seq_q) begin
               cmd_ack_d = cmd_seq;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cmd_ack_q  <= cmd_seq;
         rsp_seq_q  <= rsp_ack;
         rsp_data_q <= 8'h00;
         stage_q    <= 16'h0000;
         halt_q     <= 1'b0;
         hit_q      <= 4'h0;
      end else begin
         state_q    <= state_d;
         cmd_ack_q  <= cmd_ack_d;
         rsp_seq_q  <= rsp_seq_d;
         rsp_data_q <= rsp_data_d;
         stage_q    <= stage_d;
         halt_q     <= halt_d;
         hit_q      <= hit_d;
      end
   end

   assign cmd_ack  = cmd_ack_q;
   assign rsp_seq  = rsp_seq_q;
   assign rsp_data = rsp_data_q;
   assign halt_req = halt_q;
   assign hit_id   = hit_q;

endmodule
